// File: rtl/branch_fwd_unit.sv
// Branch-operand forwarding for the ID stage: per-stage dest tags pick the nearest ready producer and evaluate the branch condition.
// Operands, selects, taken and stall are combinational from ID inputs and tags; stall holds ID while a matched producer is not yet ready.
module branch_fwd_unit #(
    parameter int DATA_W   = 32,
    parameter int NSTAGE   = 3,
    parameter int REG_AW   = 5,
    parameter int LOAD_RDY = 2,
    parameter int SEL_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_en,
    input  logic                     flush,
    input  logic                     fwd_dis,
    input  logic                     id_we,
    input  logic                     id_is_load,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_br,
    input  logic                     id_use_rt,
    input  logic [REG_AW-1:0]        id_rs,
    input  logic [REG_AW-1:0]        id_rt,
    input  logic [2:0]               cmp_op,
    input  logic [DATA_W-1:0]        rf_a,
    input  logic [DATA_W-1:0]        rf_b,
    input  logic [NSTAGE*DATA_W-1:0] stg_data,
    output logic [DATA_W-1:0]        opa,
    output logic [DATA_W-1:0]        opb,
    output logic [SEL_W-1:0]         sel_a,
    output logic [SEL_W-1:0]         sel_b,
    output logic                     taken,
    output logic                     stall,
    output logic [15:0]              stall_cnt
);

    logic [NSTAGE-1:0]             vld_q, vld_d;
    logic [NSTAGE-1:0]             ld_q, ld_d;
    logic [NSTAGE-1:0][REG_AW-1:0] dst_q, dst_d;
    logic [15:0]                   cnt_q, cnt_d;

    logic              a_hit, a_rdy, b_hit, b_rdy;
    logic [SEL_W-1:0]  a_sel, b_sel;
    logic [DATA_W-1:0] a_dat, b_dat;
    logic              cond;

    // Walk from the oldest stage down so the youngest matching producer wins.
    always_comb begin
        a_hit = 1'b0;
        a_rdy = 1'b0;
        a_sel = '0;
        a_dat = '0;
        b_hit = 1'b0;
        b_rdy = 1'b0;
        b_sel = '0;
        b_dat = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (vld_q[k] && dst_q[k] == id_rs && id_rs != '0) begin
                a_hit = 1'b1;
                a_rdy = !ld_q[k] || (k >= LOAD_RDY);
                a_sel = SEL_W'(k + 1);
                a_dat = stg_data[k*DATA_W +: DATA_W];
            end
            if (id_use_rt && vld_q[k] && dst_q[k] == id_rt && id_rt != '0) begin
                b_hit = 1'b1;
                b_rdy = !ld_q[k] || (k >= LOAD_RDY);
                b_sel = SEL_W'(k + 1);
                b_dat = stg_data[k*DATA_W +: DATA_W];
            end
        end
        if (fwd_dis) begin
            a_rdy = 1'b0;
            b_rdy = 1'b0;
        end
    end

    always_comb begin
        stall = id_br && !flush && ((a_hit && !a_rdy) || (b_hit && !b_rdy));
        sel_a = (a_hit && a_rdy) ? a_sel : '0;
        sel_b = (b_hit && b_rdy) ? b_sel : '0;
        opa   = (a_hit && a_rdy) ? a_dat : rf_a;
        opb   = (b_hit && b_rdy) ? b_dat : rf_b;
    end

    always_comb begin
        cond = 1'b0;
        case (cmp_op)
            3'd0:    cond = (opa == opb);
            3'd1:    cond = (opa != opb);
            3'd2:    cond = ($signed(opa) <= 0);
            3'd3:    cond = ($signed(opa) > 0);
            3'd4:    cond = ($signed(opa) < 0);
            3'd5:    cond = ($signed(opa) >= 0);
            default: cond = 1'b0;
        endcase
        taken = id_br && !stall && cond;
    end

    // A stalled ID slot injects a bubble; flush already clears the valid term.
    always_comb begin
        vld_d = vld_q;
        ld_d  = ld_q;
        dst_d = dst_q;
        if (pipe_en) begin
            for (int k = NSTAGE - 1; k >= 1; k--) begin
                vld_d[k] = vld_q[k-1];
                ld_d[k]  = ld_q[k-1];
                dst_d[k] = dst_q[k-1];
            end
            vld_d[0] = !stall && id_we && (id_rd != '0) && !flush;
            ld_d[0]  = id_is_load;
            dst_d[0] = id_rd;
        end
        cnt_d = (stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            ld_q  <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            ld_q  <= ld_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule
